// File: rtl/ram_arbiter_rr_pkg.sv
// Shared types for the RAM arbiter: FSM states, arbitration mode and ID sizing.
package eei;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_e;

    function automatic int id_width(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_if.sv
// Simple memory bus: one request channel with ready/valid, one unflow-controlled read response.
interface Membus #(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [XLEN-1:0]       wdata;
    logic [XLEN/8-1:0]     wmask;
    logic                  rvalid;
    logic [XLEN-1:0]       rdata;

    modport master (
        output valid, addr, wen, wdata, wmask,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wen, wdata, wmask,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter_rr_id_fifo.sv
// In-order FIFO of master IDs for reads in flight; head names the owner of the next response.
module arb_id_fifo #(
    parameter  int DEPTH = 4,
    parameter  int ID_W  = 1,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [ID_W-1:0]  push_id,
    input  logic             pop,
    output logic [ID_W-1:0]  head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt_q;
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/ram_arbiter_rr.sv
// N-to-1 RAM arbiter with round-robin or fixed priority and in-order read response routing.
//   state      | meaning
//   ARB_IDLE   | grant re-evaluated every cycle from eligible requests
//   ARB_LOCKED | request presented but not accepted; granted master held until fire
module ram_arbiter_rr
    import eei::*;
#(
    parameter  int XLEN            = 64,
    parameter  int ADDR_WIDTH      = 32,
    parameter  int NUM_MASTERS     = 2,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int RR_MODE         = 1,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    Membus.slave             m [NUM_MASTERS],
    Membus.master            out,
    output logic [CNT_W-1:0] outstanding_cnt,
    output logic             err_rvalid
);

    localparam int        ID_W = id_width(NUM_MASTERS);
    localparam arb_mode_e MODE = (RR_MODE != 0) ? MODE_RR : MODE_FIXED;

    logic [NUM_MASTERS-1:0] m_valid;
    logic [NUM_MASTERS-1:0] m_wen;
    logic [NUM_MASTERS-1:0] m_ready;
    logic [NUM_MASTERS-1:0] m_rvalid;
    logic [NUM_MASTERS-1:0] eligible;
    logic [ADDR_WIDTH-1:0]  m_addr  [NUM_MASTERS];
    logic [XLEN-1:0]        m_wdata [NUM_MASTERS];
    logic [XLEN/8-1:0]      m_wmask [NUM_MASTERS];

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] lock_id_q;
    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_id;
    logic            pick_found;
    logic            grant_valid;
    logic            fire;
    int              rr_base;

    logic [ID_W-1:0] fifo_head;
    logic            fifo_full;
    logic            fifo_empty;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
        assign m_valid[i]  = m[i].valid;
        assign m_wen[i]    = m[i].wen;
        assign m_addr[i]   = m[i].addr;
        assign m_wdata[i]  = m[i].wdata;
        assign m_wmask[i]  = m[i].wmask;
        assign m[i].ready  = m_ready[i];
        assign m[i].rvalid = m_rvalid[i];
        assign m[i].rdata  = m_rvalid[i] ? out.rdata : '0;
    end

    // Eligibility looks only at the registered full flag, so ready never depends on rvalid.
    assign eligible = m_valid & (m_wen | {NUM_MASTERS{!fifo_full}});
    assign rr_base  = (MODE == MODE_RR) ? int'(last_grant_q) + 1 : 0;

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = ID_W'((rr_base + k) % NUM_MASTERS);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_id    = pick_id;
        grant_valid = pick_found;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found && !out.ready) state_d = ARB_LOCKED;
            end
            ARB_LOCKED: begin
                grant_id    = lock_id_q;
                grant_valid = 1'b1;
                if (out.ready) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        m_ready = '0;
        if (grant_valid) m_ready[grant_id] = out.ready;
    end

    always_comb begin
        m_rvalid = '0;
        if (out.rvalid && !fifo_empty) m_rvalid[fifo_head] = 1'b1;
    end

    assign out.valid = grant_valid;
    assign out.addr  = grant_valid ? m_addr[grant_id]  : '0;
    assign out.wen   = grant_valid & m_wen[grant_id];
    assign out.wdata = grant_valid ? m_wdata[grant_id] : '0;
    assign out.wmask = grant_valid ? m_wmask[grant_id] : '0;
    assign fire      = grant_valid && out.ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            lock_id_q    <= '0;
            last_grant_q <= ID_W'(NUM_MASTERS - 1);
            err_rvalid   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && state_d == ARB_LOCKED) lock_id_q <= grant_id;
            if (fire) last_grant_q <= grant_id;
            if (out.rvalid && fifo_empty) err_rvalid <= 1'b1;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (ID_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fire && !out.wen),
        .push_id (grant_id),
        .pop     (out.rvalid),
        .head    (fifo_head),
        .count   (outstanding_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Bench for ram_arbiter_rr: directed scenarios plus random traffic against a queue-based model.
module tb_ram_arbiter_rr;

    localparam int N  = 3;
    localparam int MO = 2;
    localparam int XL = 64;
    localparam int AW = 32;
    localparam int MW = XL / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // round-robin DUT (N=3, MAX_OUTSTANDING=2)
    logic [N-1:0]    mv = '0;
    logic [N-1:0]    mw = '0;
    logic [AW-1:0]   ma [N];
    logic [XL-1:0]   md [N];
    logic [MW-1:0]   mm [N];
    logic            ordy = 1'b0;
    logic            orv  = 1'b0;
    logic [XL-1:0]   ord  = '0;
    logic [N-1:0]    obs_rdy;
    logic [N-1:0]    obs_rv;
    logic [N*XL-1:0] obs_rd;
    logic [1:0]      cnt;
    logic            err;

    Membus #(.XLEN(XL), .ADDR_WIDTH(AW)) mif [N] ();
    Membus #(.XLEN(XL), .ADDR_WIDTH(AW)) oif ();

    for (genvar i = 0; i < N; i++) begin : g_m
        assign mif[i].valid = mv[i];
        assign mif[i].wen   = mw[i];
        assign mif[i].addr  = ma[i];
        assign mif[i].wdata = md[i];
        assign mif[i].wmask = mm[i];
        assign obs_rdy[i]   = mif[i].ready;
        assign obs_rv[i]    = mif[i].rvalid;
        assign obs_rd[i*XL +: XL] = mif[i].rdata;
    end
    assign oif.ready  = ordy;
    assign oif.rvalid = orv;
    assign oif.rdata  = ord;

    ram_arbiter_rr #(
        .XLEN(XL), .ADDR_WIDTH(AW), .NUM_MASTERS(N), .MAX_OUTSTANDING(MO), .RR_MODE(1)
    ) dut (
        .clk(clk), .rst(rst), .m(mif), .out(oif), .outstanding_cnt(cnt), .err_rvalid(err)
    );

    // fixed-priority DUT (N=3, MAX_OUTSTANDING=4)
    logic [N-1:0]  fv = '0;
    logic [N-1:0]  fw = '0;
    logic [AW-1:0] fa [N];
    logic          fr = 1'b0;
    logic [N-1:0]  f_rdy;
    logic [2:0]    fcnt;
    logic          ferr;

    Membus #(.XLEN(XL), .ADDR_WIDTH(AW)) fif [N] ();
    Membus #(.XLEN(XL), .ADDR_WIDTH(AW)) foif ();

    for (genvar i = 0; i < N; i++) begin : g_f
        assign fif[i].valid = fv[i];
        assign fif[i].wen   = fw[i];
        assign fif[i].addr  = fa[i];
        assign fif[i].wdata = '0;
        assign fif[i].wmask = '0;
        assign f_rdy[i]     = fif[i].ready;
    end
    assign foif.ready  = fr;
    assign foif.rvalid = 1'b0;
    assign foif.rdata  = '0;

    ram_arbiter_rr #(
        .XLEN(XL), .ADDR_WIDTH(AW), .NUM_MASTERS(N), .MAX_OUTSTANDING(4), .RR_MODE(0)
    ) dut_fx (
        .clk(clk), .rst(rst), .m(fif), .out(foif), .outstanding_cnt(fcnt), .err_rvalid(ferr)
    );

    // reference model: in-flight reads as a queue of master IDs, RAM as a queue of due cycles
    int q[$];
    int dueq[$];
    int last_g = N - 1;
    int lock_g = -1;
    int cyc = 0;
    int lat = 1;
    int gap = 1;
    int last_due = -1000;
    bit m_err = 1'b0;
    bit auto_drop = 1'b0;
    bit force_rv = 1'b0;

    logic [N-1:0]  s_rdy;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [1:0]    s_cnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        dueq.delete();
        last_g   = N - 1;
        lock_g   = -1;
        m_err    = 1'b0;
        last_due = -1000;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One cycle: drive RAM response, compare at negedge, advance model after posedge.
    task automatic step();
        int g;
        int idx;
        int head;
        bit ev;
        bit fire;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        orv = force_rv || (dueq.size() > 0 && dueq[0] <= cyc);
        ord = orv ? {$urandom, $urandom} : '0;
        @(negedge clk);
        g = -1;
        if (lock_g >= 0) g = lock_g;
        else begin
            for (int k = 0; k < N; k++) begin
                idx = (last_g + 1 + k) % N;
                if (g < 0 && mv[idx] && (mw[idx] || q.size() < MO)) g = idx;
            end
        end
        ev = (g >= 0);
        exp_rdy = '0;
        if (ev && ordy) exp_rdy[g] = 1'b1;
        head = (q.size() > 0) ? q[0] : -1;
        exp_rv = '0;
        if (orv && head >= 0) exp_rv[head] = 1'b1;
        s_rdy   = obs_rdy;
        s_valid = oif.valid;
        s_addr  = oif.addr;
        s_cnt   = cnt;
        chk("out_valid", oif.valid, ev);
        chk("out_addr", oif.addr, ev ? ma[g] : '0);
        chk("out_wen", oif.wen, ev ? mw[g] : 1'b0);
        chk("out_wdata", oif.wdata, ev ? md[g] : '0);
        chk("out_wmask", oif.wmask, ev ? mm[g] : '0);
        chk("m_ready", obs_rdy, exp_rdy);
        chk("m_rvalid", obs_rv, exp_rv);
        for (int i = 0; i < N; i++) chk("m_rdata", obs_rd[i*XL +: XL], exp_rv[i] ? ord : '0);
        chk("outstanding_cnt", cnt, q.size());
        chk("err_rvalid", err, m_err);
        @(posedge clk);
        #1;
        fire = ev && ordy;
        if (orv) begin
            if (q.size() == 0) m_err = 1'b1;
            else begin
                void'(q.pop_front());
                void'(dueq.pop_front());
            end
        end
        if (fire) begin
            last_g = g;
            if (!mw[g]) begin
                q.push_back(g);
                if (cyc + lat > last_due + gap) last_due = cyc + lat;
                else last_due = last_due + gap;
                dueq.push_back(last_due);
            end
            if (auto_drop) mv[g] = 1'b0;
        end
        lock_g   = (ev && !ordy) ? g : -1;
        cyc++;
        force_rv = 1'b0;
        orv      = 1'b0;
        ord      = '0;
    endtask

    task automatic drain();
        mv   = '0;
        ordy = 1'b1;
        for (int i = 0; i < 40 && (q.size() > 0 || lock_g >= 0); i++) step();
        chk("drain_cnt", cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            ma[i] = '0; md[i] = '0; mm[i] = '0; fa[i] = '0;
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        @(negedge clk);
        chk("rst_cnt", cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_out_valid", oif.valid, 0);
        chk("rst_ready", obs_rdy, 0);
        chk("rst_fx_cnt", fcnt, 0);
        chk("rst_fx_err", ferr, 0);
        @(posedge clk);
        #1;

        // fixed priority: master 0 wins until its reads hit the limit, then master 2's write goes
        fa[0] = 32'h100; fa[2] = 32'h300;
        fw = 3'b100; fv = 3'b101; fr = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("fx_addr", foif.addr, 32'h100);
            chk("fx_ready", f_rdy, 3'b001);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("fx_cnt_full", fcnt, 4);
        chk("fx_skip_read", f_rdy, 3'b100);
        chk("fx_addr_m2", foif.addr, 32'h300);
        @(posedge clk);
        #1 fv = '0;

        // round-robin with three continuous readers, responses one cycle later
        for (int i = 0; i < N; i++) ma[i] = AW'(32'h1000 + i * 16);
        mw = '0; mv = 3'b111; ordy = 1'b1; lat = 1; gap = 1; auto_drop = 1'b0;
        for (int s = 0; s < 6; s++) begin
            step();
            chk("rr_order", s_rdy, N'(1) << (s % 3));
            if (s > 0) chk("pushpop_cnt", s_cnt, 1);
        end
        drain();

        // outstanding limit with slow responses
        mv = 3'b111; mw = '0; auto_drop = 1'b1; lat = 5; gap = 5; last_due = -1000; ordy = 1'b1;
        for (int s = 0; s < 8; s++) begin
            step();
            if (s >= 2 && s <= 5) begin
                chk("limit_block", s_valid, 0);
                chk("limit_cnt_full", s_cnt, 2);
            end
            if (s == 6) begin
                chk("limit_cnt_after_rv", s_cnt, 1);
                chk("limit_third_grant", s_valid, 1);
            end
            if (s == 7) chk("limit_cnt_refill", s_cnt, 2);
        end
        drain();
        lat = 1; gap = 1;

        // grant lock while out.ready is low
        do_reset();
        ma[1] = 32'hABC0; ma[0] = 32'h5550; mw = '0; mv = 3'b010; ordy = 1'b0; auto_drop = 1'b1;
        step();
        chk("lock_first", s_addr, 32'hABC0);
        mv[0] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("lock_hold", s_addr, 32'hABC0);
        end
        ordy = 1'b1;
        step();
        chk("lock_fire", s_rdy, 3'b010);
        step();
        chk("after_lock", s_rdy, 3'b001);
        drain();

        // reset mid-read, then a stray response
        mv = 3'b001; ma[0] = 32'h7770; mw = '0; ordy = 1'b1; lat = 20;
        step();
        chk("pre_rst_cnt", cnt, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_cnt", cnt, 0);
        chk("rst_async_err", err, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        lat = 1;
        force_rv = 1'b1;
        step();
        chk("stray_rvalid", s_rdy | obs_rv, 0);
        step();
        chk("err_sticky", err, 1);

        // random traffic
        do_reset();
        auto_drop = 1'b1; gap = 1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!mv[i] && $urandom_range(0, 2) == 0) begin
                    mv[i] = 1'b1;
                    mw[i] = 1'($urandom_range(0, 1));
                    ma[i] = $urandom;
                    md[i] = {$urandom, $urandom};
                    mm[i] = MW'($urandom);
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            lat  = $urandom_range(1, 6);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
